uart_hash_framer: RTL and testbench
===================================

# uart_hash_framer

Parametrised framing bridge between the UART byte streams and the hash core. It parses a big-endian length header from the receive AXI-stream, packs payload bytes into `WORD_W`-bit words for the hash core's start/valid/last/ready interface, captures the digest, and serialises it MSB-byte-first onto the transmit AXI-stream. It replaces hand-written per-byte read states in the top level and sits between `uart_rx`/`uart_tx` and `sha`.

## Interface
- `WORD_W`, 32: hash-core input word width; multiple of 8, 8..64.
- `HASH_W`, 512: digest width; multiple of 8.
- `LEN_BYTES`, 4: header length field size in bytes, 1..4.
- `TIMEOUT_CYCLES`, 16'd50000: inter-byte timeout; used only with `FRAMER_TIMEOUT_EN`.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  8  byte from `uart_rx`.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tready`  out  1  byte accepted when high with tvalid.
- `m_axis_tdata`  out  8  byte to `uart_tx`.
- `m_axis_tvalid`  out  1  byte valid.
- `m_axis_tready`  in  1  downstream ready.
- `start`  out  1  one-cycle pulse that opens a message.
- `data_in`  out  WORD_W  packed word; first byte in the MSBs.
- `data_valid`  out  1  word valid.
- `data_last`  out  1  final word of the message; qualified by data_valid.
- `last_bytes`  out  $clog2(WORD_W/8)+1  valid bytes in the last word; 0 for an empty message.
- `data_in_ready`  in  1  hash core accepts the word.
- `hash`  in  HASH_W  digest.
- `out_valid`  in  1  digest valid.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LEN, START, PAYLOAD, PUSH, WAIT_HASH, SEND.
- IDLE: `s_axis_tready` is 0. Moves to LEN on the next cycle and clears the length register and the byte counters.
- LEN: `s_axis_tready` is 1. Shifts `LEN_BYTES` bytes into `length`, MSB first. The cycle after the last header byte is accepted, the block enters START.
- START: `start` is 1 for exactly one cycle.
  - Next state is PAYLOAD if `length` is not 0.
  - Next state is PUSH if `length` is 0, with `data_in` = 0, `data_last` = 1 and `last_bytes` = 0.
- PAYLOAD: `s_axis_tready` is 1. Each accepted byte goes into the next lane, MSB lane first, and decrements `length`. Enters PUSH when a word fills or `length` reaches 0. Unused lanes are zero-padded.
- PUSH: `s_axis_tready` is 0, `data_valid` is 1, and `data_in`, `data_last` and `last_bytes` are held stable until `data_valid && data_in_ready`.
  - `data_last` = 1 only when `length` = 0.
  - `last_bytes` = filled lanes on the last word, else `WORD_W/8`.
  - After the transfer: next state is PAYLOAD if `data_last` = 0, else WAIT_HASH.
- WAIT_HASH: when `out_valid` = 1, `hash` is loaded into the shift register and the block enters SEND. `out_valid` is ignored in all other states.
- SEND: `m_axis_tdata` = shift register `[HASH_W-1 -: 8]` with `m_axis_tvalid` = 1. Each `m_axis_tready` handshake shifts left by 8. After `HASH_W/8` bytes the block returns to IDLE.
- Length is unsigned, `8*LEN_BYTES` bits wide; the maximum value is legal. Byte counters wrap only by reload.

## Timing
- Reset values: `s_axis_tready`, `m_axis_tvalid`, `m_axis_tdata`, `start`, `data_in`, `data_valid`, `data_last`, `last_bytes` and `busy` are all 0. State is IDLE.
- `rst` mid-operation: everything returns to reset values on the next edge. Partial words and digest bytes are discarded and no `data_last` is emitted.
- Latency:
  - Last header byte accepted in cycle N: `start` in N+1, `s_axis_tready` high in N+2.
  - Word-completing byte accepted in cycle N: `data_valid` in N+1. `s_axis_tready` is 0 until the cycle after the handshake.
  - `out_valid` sampled in cycle N: first `m_axis_tvalid` in N+1.
- `s_axis_tvalid` without `s_axis_tready`: the byte is not consumed. The block never drops a byte.
- `m_axis_tvalid` never deasserts before the handshake. `data_valid` never deasserts before `data_in_ready`.
- Throughput: one byte per cycle in LEN and PAYLOAD; one hash word per `WORD_W/8` bytes plus one PUSH cycle.

## Configuration
- `FRAMER_TIMEOUT_EN` defined:
  - A 16-bit counter reloads to `TIMEOUT_CYCLES` on every accepted byte and counts down in LEN and PAYLOAD.
  - At 0, the block enters an ABORT state and sends one byte 0xEE on `m_axis`, then returns to IDLE.
  - `start` already issued is not retracted. The next frame's `start` reopens the core.
- Not defined: no counter and no ABORT state. The block waits indefinitely for bytes.

## Test plan
- Header 00 00 00 04, payload 61 62 63 64, core ready -> one word `data_in`=0x61626364, `data_last`=1, `last_bytes`=4. A digest of 0x00..3F serialises as 64 bytes 0x00, 0x01, ... 0x3F.
- Length 5, payload 01..05 -> words 0x01020304 (`last`=0), then 0x05000000 (`last`=1, `last_bytes`=1).
- Length 0 -> `start`, one word 0x00000000 with `data_last`=1 and `last_bytes`=0, then WAIT_HASH.
- `data_in_ready` low for 7 cycles, random `m_axis_tready` -> `data_in` is held, no bytes are lost, and the digest byte order is preserved.
- `rst` asserted after 2 payload bytes -> all outputs are 0 next cycle. A fresh frame of length 4 then completes normally.
- With `FRAMER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: stall after 2 header bytes -> 0xEE emitted 100 cycles after the last byte, `busy` falls, and the block enters IDLE.

Source files
------------

// File: rtl/uart_hash_framer.sv
// uart_hash_framer: turns a length-prefixed byte frame into hash-core words and serialises the
// digest back out MSB byte first. Define FRAMER_TIMEOUT_EN for the inter-byte timeout/abort path.
module uart_hash_framer #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned HASH_W         = 512,
  parameter int unsigned LEN_BYTES      = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      start,
  output logic [WORD_W-1:0]         data_in,
  output logic                      data_valid,
  output logic                      data_last,
  output logic [$clog2(WORD_W/8):0] last_bytes,
  input  logic                      data_in_ready,
  input  logic [HASH_W-1:0]         hash,
  input  logic                      out_valid,
  output logic                      busy
);

  localparam int unsigned Lanes = WORD_W / 8;
  localparam int unsigned LaneW = $clog2(Lanes) + 1;
  localparam int unsigned LenW  = 8 * LEN_BYTES;
  localparam int unsigned HdrW  = $clog2(LEN_BYTES) + 1;
  localparam int unsigned HashB = HASH_W / 8;
  localparam int unsigned SendW = $clog2(HashB) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StStart,
    StPayload,
    StPush,
    StWaitHash,
`ifdef FRAMER_TIMEOUT_EN
    StSend,
    StAbort
`else
    StSend
`endif
  } state_e;

  state_e              state_q;
  logic [LenW-1:0]     len_q;
  logic [HdrW-1:0]     hdr_cnt_q;
  logic [LaneW-1:0]    lane_q;
  logic [WORD_W-1:0]   word_q;
  logic [HASH_W-1:0]   shreg_q;
  logic [SendW-1:0]    send_cnt_q;

  logic                s_tready_q;
  logic                m_tvalid_q;
  logic                start_q;
  logic [WORD_W-1:0]   din_q;
  logic                dvalid_q;
  logic                dlast_q;
  logic [LaneW-1:0]    lbytes_q;
  logic                busy_q;

`ifdef FRAMER_TIMEOUT_EN
  logic [15:0]         tmo_q;
`else
  logic                unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  logic                s_fire;
  logic                m_fire;
  logic [WORD_W-1:0]   word_next;

  assign s_fire = s_axis_tvalid && s_tready_q;
  assign m_fire = m_tvalid_q && m_axis_tready;

  // Lane 0 is the most significant byte of the word.
  always_comb begin
    word_next = word_q | (WORD_W'(s_axis_tdata) << (8 * (Lanes - 1 - 32'(lane_q))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      hdr_cnt_q  <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      shreg_q    <= '0;
      send_cnt_q <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      start_q    <= 1'b0;
      din_q      <= '0;
      dvalid_q   <= 1'b0;
      dlast_q    <= 1'b0;
      lbytes_q   <= '0;
      busy_q     <= 1'b0;
`ifdef FRAMER_TIMEOUT_EN
      tmo_q      <= TIMEOUT_CYCLES;
`endif
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q    <= StLen;
          busy_q     <= 1'b1;
          s_tready_q <= 1'b1;
          len_q      <= '0;
          hdr_cnt_q  <= '0;
          lane_q     <= '0;
          word_q     <= '0;
        end
        StLen: begin
          if (s_fire) begin
            len_q <= (len_q << 8) | LenW'(s_axis_tdata);
            if (hdr_cnt_q == HdrW'(LEN_BYTES - 1)) begin
              state_q    <= StStart;
              s_tready_q <= 1'b0;
              start_q    <= 1'b1;
            end else begin
              hdr_cnt_q <= hdr_cnt_q + HdrW'(1);
            end
          end
        end
        StStart: begin
          lane_q <= '0;
          word_q <= '0;
          if (len_q != '0) begin
            state_q    <= StPayload;
            s_tready_q <= 1'b1;
          end else begin
            // Empty message still hands the core one terminating word.
            state_q  <= StPush;
            din_q    <= '0;
            dlast_q  <= 1'b1;
            lbytes_q <= '0;
            dvalid_q <= 1'b1;
          end
        end
        StPayload: begin
          if (s_fire) begin
            len_q <= len_q - LenW'(1);
            if (lane_q == LaneW'(Lanes - 1) || len_q == LenW'(1)) begin
              state_q    <= StPush;
              s_tready_q <= 1'b0;
              dvalid_q   <= 1'b1;
              din_q      <= word_next;
              dlast_q    <= (len_q == LenW'(1));
              lbytes_q   <= lane_q + LaneW'(1);
            end else begin
              lane_q <= lane_q + LaneW'(1);
              word_q <= word_next;
            end
          end
        end
        StPush: begin
          if (data_in_ready) begin
            dvalid_q <= 1'b0;
            lane_q   <= '0;
            word_q   <= '0;
            if (dlast_q) begin
              state_q  <= StWaitHash;
              dlast_q  <= 1'b0;
              lbytes_q <= '0;
            end else begin
              state_q    <= StPayload;
              s_tready_q <= 1'b1;
            end
          end
        end
        StWaitHash: begin
          if (out_valid) begin
            shreg_q    <= hash;
            send_cnt_q <= '0;
            m_tvalid_q <= 1'b1;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (m_fire) begin
            shreg_q <= shreg_q << 8;
            if (send_cnt_q == SendW'(HashB - 1)) begin
              state_q    <= StIdle;
              m_tvalid_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              send_cnt_q <= send_cnt_q + SendW'(1);
            end
          end
        end
`ifdef FRAMER_TIMEOUT_EN
        StAbort: begin
          if (m_fire) begin
            shreg_q    <= '0;
            state_q    <= StIdle;
            m_tvalid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase

`ifdef FRAMER_TIMEOUT_EN
      // Counts only while waiting on the UART; overrides the case above on expiry.
      if (state_q == StLen || state_q == StPayload) begin
        if (s_fire) begin
          tmo_q <= TIMEOUT_CYCLES;
        end else if (tmo_q <= 16'd1) begin
          state_q    <= StAbort;
          s_tready_q <= 1'b0;
          m_tvalid_q <= 1'b1;
          shreg_q    <= {8'hEE, {(HASH_W - 8){1'b0}}};
        end else begin
          tmo_q <= tmo_q - 16'd1;
        end
      end else begin
        tmo_q <= TIMEOUT_CYCLES;
      end
`endif
    end
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tdata  = shreg_q[HASH_W-1 -: 8];
  assign m_axis_tvalid = m_tvalid_q;
  assign start         = start_q;
  assign data_in       = din_q;
  assign data_valid    = dvalid_q;
  assign data_last     = dlast_q;
  assign last_bytes    = lbytes_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_hash_framer.sv
`timescale 1ns/1ps
// Directed bench for uart_hash_framer: framing, word packing, digest order, backpressure, reset.
module tb_uart_hash_framer;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned HASH_W    = 512;
  localparam int unsigned LEN_BYTES = 4;
  localparam int unsigned HB        = HASH_W / 8;
`ifdef FRAMER_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'd100;
`else
  localparam logic [15:0] TMO = 16'd50000;
`endif

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic [7:0]        s_tdata   = 8'h00;
  logic              s_tvalid  = 1'b0;
  logic              s_tready;
  logic [7:0]        m_tdata;
  logic              m_tvalid;
  logic              mrdy      = 1'b1;
  logic              start;
  logic [31:0]       data_in;
  logic              data_valid;
  logic              data_last;
  logic [2:0]        last_bytes;
  logic              rdy       = 1'b1;
  logic [HASH_W-1:0] hash      = '0;
  logic              out_valid = 1'b0;
  logic              busy;
  logic              mrand     = 1'b0;

  int vec = 0;
  int err = 0;

  uart_hash_framer #(
    .WORD_W        (WORD_W),
    .HASH_W        (HASH_W),
    .LEN_BYTES     (LEN_BYTES),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(mrdy),
    .start        (start),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_last    (data_last),
    .last_bytes   (last_bytes),
    .data_in_ready(rdy),
    .hash         (hash),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    mrdy <= mrand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Handshake capture and hold-stability tracking, sampled on the falling edge.
  logic [31:0] wq[$];
  logic        lq[$];
  logic [2:0]  bq[$];
  logic [7:0]  mq[$];
  int          hold_viol  = 0;
  int          mhold_viol = 0;
  logic        dv_stall   = 1'b0;
  logic        m_stall    = 1'b0;
  logic [31:0] din_prev;
  logic        last_prev;
  logic [2:0]  lb_prev;
  logic [7:0]  md_prev;

  always @(negedge clk) begin
    if (rst) begin
      dv_stall <= 1'b0;
      m_stall  <= 1'b0;
    end else begin
      if (dv_stall && (!data_valid || data_in !== din_prev || data_last !== last_prev ||
                       last_bytes !== lb_prev))
        hold_viol <= hold_viol + 1;
      if (m_stall && (!m_tvalid || m_tdata !== md_prev)) mhold_viol <= mhold_viol + 1;
      if (data_valid && rdy) begin
        wq.push_back(data_in);
        lq.push_back(data_last);
        bq.push_back(last_bytes);
      end
      if (m_tvalid && mrdy) mq.push_back(m_tdata);
      dv_stall  <= data_valid && !rdy;
      din_prev  <= data_in;
      last_prev <= data_last;
      lb_prev   <= last_bytes;
      m_stall   <= m_tvalid && !mrdy;
      md_prev   <= m_tdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    s_tdata  = b;
    s_tvalid = 1'b1;
    t = 0;
    while (!s_tready && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) begin
      vec++;
      err++;
      $display("FAIL send_byte_timeout: byte %h tready=%b required 1", b, s_tready);
    end
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] len);
    for (int i = LEN_BYTES - 1; i >= 0; i--) send_byte(len[8*i +: 8]);
  endtask

  task automatic present_digest(input logic [HASH_W-1:0] h);
    int t;
    mq.delete();
    hash      = h;
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    t = 0;
    while (mq.size() < HB && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) begin
      vec++;
      err++;
      $display("FAIL digest_timeout: got %0d bytes required %0d", mq.size(), HB);
    end
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (wq.size() < n && t < 300) begin
      tick();
      t++;
    end
  endtask

  task automatic test_reset();
    logic [48:0] obs;
    tick();
    tick();
    obs = {s_tready, m_tvalid, m_tdata, start, data_in, data_valid, data_last, last_bytes, busy};
    vec++;
    if (obs !== '0) begin
      err++;
      $display("FAIL reset_outputs: got %h required 0", obs);
    end
    rst = 1'b0;
    tick();
    vec++;
    if (s_tready !== 1'b1 || busy !== 1'b1) begin
      err++;
      $display("FAIL idle_to_len: tready=%b busy=%b required 1 1", s_tready, busy);
    end
  endtask

  task automatic test_basic();
    logic [HASH_W-1:0] h;
    logic [7:0]        eb[HB];
    int                t;
    int                bad;
    wq.delete(); lq.delete(); bq.delete();
    send_header(32'd4);
    vec++;
    if (start !== 1'b1 || s_tready !== 1'b0) begin
      err++;
      $display("FAIL start_latency: start=%b tready=%b required 1 0", start, s_tready);
    end
    tick();
    vec++;
    if (start !== 1'b0 || s_tready !== 1'b1) begin
      err++;
      $display("FAIL payload_ready: start=%b tready=%b required 0 1", start, s_tready);
    end
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63); send_byte(8'h64);
    vec++;
    if (data_valid !== 1'b1 || s_tready !== 1'b0) begin
      err++;
      $display("FAIL push_latency: data_valid=%b tready=%b required 1 0", data_valid, s_tready);
    end
    vec++;
    if (data_in !== 32'h61626364 || data_last !== 1'b1 || last_bytes !== 3'd4) begin
      err++;
      $display("FAIL basic_word: got %h/%b/%0d required 61626364/1/4",
               data_in, data_last, last_bytes);
    end
    tick();
    vec++;
    if (data_valid !== 1'b0 || wq.size() != 1) begin
      err++;
      $display("FAIL basic_handoff: data_valid=%b words=%0d required 0 1", data_valid, wq.size());
    end
    for (int i = 0; i < HB; i++) begin
      eb[i] = 8'(i);
      h[HASH_W-1-8*i -: 8] = eb[i];
    end
    mq.delete();
    hash      = h;
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    vec++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'h00) begin
      err++;
      $display("FAIL digest_latency: tvalid=%b tdata=%h required 1 00", m_tvalid, m_tdata);
    end
    t = 0;
    while (mq.size() < HB && t < 3000) begin
      tick();
      t++;
    end
    vec++;
    bad = -1;
    for (int i = 0; i < HB; i++)
      if (bad < 0 && (i >= mq.size() || mq[i] !== eb[i])) bad = i;
    if (bad >= 0) begin
      err++;
      $display("FAIL basic_digest: byte %0d of %0d received, required %h", bad, mq.size(),
               eb[bad]);
    end
    vec++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      err++;
      $display("FAIL idle_after_send: busy=%b tvalid=%b required 0 0", busy, m_tvalid);
    end
  endtask

  task automatic test_len5();
    logic [HASH_W-1:0] h;
    logic [7:0]        eb[HB];
    int                bad;
    wq.delete(); lq.delete(); bq.delete();
    send_header(32'd5);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    wait_words(2);
    vec++;
    if (wq.size() != 2) begin
      err++;
      $display("FAIL len5_count: got %0d words required 2", wq.size());
    end else begin
      vec++;
      if (wq[0] !== 32'h01020304 || lq[0] !== 1'b0 || bq[0] !== 3'd4) begin
        err++;
        $display("FAIL len5_word0: got %h/%b/%0d required 01020304/0/4", wq[0], lq[0], bq[0]);
      end
      vec++;
      if (wq[1] !== 32'h05000000 || lq[1] !== 1'b1 || bq[1] !== 3'd1) begin
        err++;
        $display("FAIL len5_word1: got %h/%b/%0d required 05000000/1/1", wq[1], lq[1], bq[1]);
      end
    end
    for (int i = 0; i < HB; i++) begin
      eb[i] = 8'(255 - i);
      h[HASH_W-1-8*i -: 8] = eb[i];
    end
    present_digest(h);
    vec++;
    bad = -1;
    for (int i = 0; i < HB; i++)
      if (bad < 0 && (i >= mq.size() || mq[i] !== eb[i])) bad = i;
    if (bad >= 0) begin
      err++;
      $display("FAIL len5_digest: byte %0d of %0d received, required %h", bad, mq.size(), eb[bad]);
    end
  endtask

  task automatic test_len0();
    logic [HASH_W-1:0] h;
    logic [7:0]        eb[HB];
    int                bad;
    wq.delete(); lq.delete(); bq.delete();
    send_header(32'd0);
    vec++;
    if (start !== 1'b1) begin
      err++;
      $display("FAIL len0_start: start=%b required 1", start);
    end
    tick();
    vec++;
    if (data_valid !== 1'b1 || data_in !== 32'h0 || data_last !== 1'b1 || last_bytes !== 3'd0 ||
        s_tready !== 1'b0) begin
      err++;
      $display("FAIL len0_word: dv=%b din=%h last=%b lb=%0d tready=%b required 1 0 1 0 0",
               data_valid, data_in, data_last, last_bytes, s_tready);
    end
    tick();
    vec++;
    if (data_valid !== 1'b0 || wq.size() != 1) begin
      err++;
      $display("FAIL len0_handoff: data_valid=%b words=%0d required 0 1", data_valid, wq.size());
    end
    for (int i = 0; i < HB; i++) begin
      eb[i] = 8'(3 * i + 1);
      h[HASH_W-1-8*i -: 8] = eb[i];
    end
    present_digest(h);
    vec++;
    bad = -1;
    for (int i = 0; i < HB; i++)
      if (bad < 0 && (i >= mq.size() || mq[i] !== eb[i])) bad = i;
    if (bad >= 0) begin
      err++;
      $display("FAIL len0_digest: byte %0d of %0d received, required %h", bad, mq.size(), eb[bad]);
    end
  endtask

  task automatic test_back_to_back();
    logic [HASH_W-1:0] h;
    logic [7:0]        eb[HB];
    int                bad;
    int                t;
    wq.delete(); lq.delete(); bq.delete();
    rdy = 1'b0;
    fork
      begin
        send_header(32'd8);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i));
      end
      begin
        t = 0;
        while (!data_valid && t < 500) begin
          tick();
          t++;
        end
        for (int c = 0; c < 7; c++) begin
          vec++;
          if (data_valid !== 1'b1 || data_in !== 32'h11121314 || s_tready !== 1'b0) begin
            err++;
            $display("FAIL stall_hold: cycle %0d dv=%b din=%h tready=%b required 1 11121314 0",
                     c, data_valid, data_in, s_tready);
          end
          tick();
        end
        rdy = 1'b1;
      end
    join
    wait_words(2);
    vec++;
    if (wq.size() != 2) begin
      err++;
      $display("FAIL b2b_count: got %0d words required 2", wq.size());
    end else begin
      vec++;
      if (wq[0] !== 32'h11121314 || lq[0] !== 1'b0 || wq[1] !== 32'h15161718 ||
          lq[1] !== 1'b1 || bq[1] !== 3'd4) begin
        err++;
        $display("FAIL b2b_words: got %h/%b %h/%b/%0d required 11121314/0 15161718/1/4",
                 wq[0], lq[0], wq[1], lq[1], bq[1]);
      end
    end
    vec++;
    if (hold_viol != 0) begin
      err++;
      $display("FAIL b2b_word_stable: got %0d changes while stalled required 0", hold_viol);
    end
    for (int i = 0; i < HB; i++) begin
      eb[i] = 8'(7 * i + 8'h5A);
      h[HASH_W-1-8*i -: 8] = eb[i];
    end
    mrand = 1'b1;
    present_digest(h);
    mrand = 1'b0;
    vec++;
    bad = -1;
    for (int i = 0; i < HB; i++)
      if (bad < 0 && (i >= mq.size() || mq[i] !== eb[i])) bad = i;
    if (bad >= 0) begin
      err++;
      $display("FAIL b2b_digest: byte %0d of %0d received, required %h", bad, mq.size(), eb[bad]);
    end
    vec++;
    if (mhold_viol != 0) begin
      err++;
      $display("FAIL tx_stable: got %0d changes before handshake required 0", mhold_viol);
    end
  endtask

  task automatic test_rst_mid();
    logic [48:0]       obs;
    logic [HASH_W-1:0] h;
    logic [7:0]        eb[HB];
    int                bad;
    wq.delete(); lq.delete(); bq.delete();
    send_header(32'd4);
    tick();
    send_byte(8'hA1);
    send_byte(8'hA2);
    rst = 1'b1;
    tick();
    obs = {s_tready, m_tvalid, m_tdata, start, data_in, data_valid, data_last, last_bytes, busy};
    vec++;
    if (obs !== '0) begin
      err++;
      $display("FAIL rst_mid_outputs: got %h required 0", obs);
    end
    rst = 1'b0;
    vec++;
    if (wq.size() != 0) begin
      err++;
      $display("FAIL rst_mid_no_word: got %0d words required 0", wq.size());
    end
    send_header(32'd4);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_words(1);
    vec++;
    if (wq.size() != 1 || wq[0] !== 32'hAABBCCDD || lq[0] !== 1'b1 || bq[0] !== 3'd4) begin
      err++;
      $display("FAIL rst_mid_fresh_word: words=%0d first=%h required 1 AABBCCDD",
               wq.size(), (wq.size() > 0) ? wq[0] : 32'h0);
    end
    for (int i = 0; i < HB; i++) begin
      eb[i] = 8'(8'h80 + i);
      h[HASH_W-1-8*i -: 8] = eb[i];
    end
    present_digest(h);
    vec++;
    bad = -1;
    for (int i = 0; i < HB; i++)
      if (bad < 0 && (i >= mq.size() || mq[i] !== eb[i])) bad = i;
    if (bad >= 0) begin
      err++;
      $display("FAIL rst_mid_digest: byte %0d of %0d received, required %h", bad, mq.size(),
               eb[bad]);
    end
  endtask

`ifdef FRAMER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    send_byte(8'h00);
    send_byte(8'h00);
    n = 0;
    while (!m_tvalid && n < 400) begin
      tick();
      n++;
    end
    vec++;
    if (n != 100 || m_tdata !== 8'hEE) begin
      err++;
      $display("FAIL timeout_abort: after %0d cycles tdata=%h required 100 EE", n, m_tdata);
    end
    tick();
    vec++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      err++;
      $display("FAIL timeout_idle: busy=%b tvalid=%b required 0 0", busy, m_tvalid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len5();
    test_len0();
    test_back_to_back();
    test_rst_mid();
`ifdef FRAMER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
